// File: rtl/sc_pkg.sv
// ---------------------------------------------------------------------------
// sc_pkg
// Shared constants and helpers for the stochastic-computing datapath
// (Sobol RNG family, bitstream generator and bitstream decoder).
//   INWD_MIN / INWD_MAX : legal range of the binary width INWD
//   sat_trunc()         : folds a window count of 0..2**inwd into an
//                         inwd-bit value, saturating 2**inwd to 2**inwd-1
// ---------------------------------------------------------------------------
package sc_pkg;

   localparam int unsigned INWD_MIN = 3;
   localparam int unsigned INWD_MAX = 10;

   // Result is INWD_MAX bits wide; callers keep the low inwd bits.
   function automatic logic [INWD_MAX-1:0] sat_trunc(input logic [INWD_MAX:0] sum,
                                                     input int unsigned       inwd);
      logic [INWD_MAX:0] full;
      logic [INWD_MAX:0] mask;
      full = {{INWD_MAX{1'b0}}, 1'b1} << inwd;
      mask = full - {{INWD_MAX{1'b0}}, 1'b1};
      if (sum == full) begin
         return mask[INWD_MAX-1:0];
      end
      return INWD_MAX'(sum & mask);
   endfunction

endpackage

// File: rtl/sc_win_cnt.sv
// ---------------------------------------------------------------------------
// sc_win_cnt
// Enabled W-bit wrap counter with a last-beat flag; shared by the bitstream
// decoder and bitstream generator.
//   clk     in  clock, rising edge
//   rst_n   in  asynchronous active-low reset
//   en_i    in  advance the count this cycle
//   clr_i   in  synchronous restart to 0, priority over en_i
//   last_o  out en_i is high and the count is at 2**W-1 (final beat)
// ---------------------------------------------------------------------------
module sc_win_cnt
   import sc_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic clr_i,
   output logic last_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         // Natural W-bit overflow gives the wrap from 2**W-1 to 0.
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last_o = en_i && (cnt_q == '1);

endmodule

// File: rtl/sc_bitstream_decoder.sv
// ---------------------------------------------------------------------------
// sc_bitstream_decoder
// Converts a unary stochastic bitstream back to binary: counts ones over a
// window of 2**INWD enabled cycles and emits one INWD-bit value per window.
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   enable    in   bitIn valid this cycle; low stalls all state
//   clear     in   synchronous window restart, priority over enable
//   bitIn     in   stochastic bit
//   binOut    out  [INWD] decoded value of the last completed window
//   outValid  out  one-cycle pulse, binOut updated this cycle
//   satFlag   out  with outValid: window was all ones, binOut saturated
// ---------------------------------------------------------------------------
module sc_bitstream_decoder
   import sc_pkg::*;
#(
   parameter int unsigned INWD = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            enable,
   input  logic            clear,
   input  logic            bitIn,
   output logic [INWD-1:0] binOut,
   output logic            outValid,
   output logic            satFlag
);

   localparam logic [INWD:0] FULL = {1'b1, {INWD{1'b0}}};

   logic            last_beat;
   logic [INWD:0]   acc_q,    acc_d;
   logic [INWD-1:0] binOut_q, binOut_d;
   logic            valid_q,  valid_d;
   logic            sat_q,    sat_d;
   logic [INWD:0]   sum;

   sc_win_cnt #(
      .W (INWD)
   ) u_win_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (enable),
      .clr_i  (clear),
      .last_o (last_beat)
   );

   assign sum = acc_q + {{INWD{1'b0}}, bitIn};

   always_comb begin
      acc_d    = acc_q;
      binOut_d = binOut_q;
      sat_d    = sat_q;
      valid_d  = 1'b0;
      if (clear) begin
         // Partial window dropped; last completed result is kept.
         acc_d = '0;
      end else if (enable) begin
         if (last_beat) begin
            binOut_d = INWD'(sat_trunc((INWD_MAX+1)'(sum), INWD));
            sat_d    = (sum == FULL);
            valid_d  = 1'b1;
            acc_d    = '0;
         end else begin
            acc_d = sum;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         binOut_q <= '0;
         valid_q  <= 1'b0;
         sat_q    <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         binOut_q <= binOut_d;
         valid_q  <= valid_d;
         sat_q    <= sat_d;
      end
   end

   assign binOut   = binOut_q;
   assign outValid = valid_q;
   assign satFlag  = sat_q;

endmodule

// File: tb/tb_sc_bitstream_decoder.sv
module tb_sc_bitstream_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable, clear, bitIn;
   logic [2:0] binOut;
   logic       outValid, satFlag;
   logic       enable8, clear8, bitIn8;
   logic [7:0] binOut8;
   logic       outValid8, satFlag8;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sc_bitstream_decoder #(.INWD(3)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .clear    (clear),
      .bitIn    (bitIn),
      .binOut   (binOut),
      .outValid (outValid),
      .satFlag  (satFlag)
   );

   sc_bitstream_decoder #(.INWD(8)) dut8 (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable8),
      .clear    (clear8),
      .bitIn    (bitIn8),
      .binOut   (binOut8),
      .outValid (outValid8),
      .satFlag  (satFlag8)
   );

   // Drive one cycle on the INWD=3 instance; return 1 time unit after the edge.
   task automatic step(input logic en, input logic b, input logic clr);
      enable = en;
      bitIn  = b;
      clear  = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic step8(input logic b);
      enable8 = 1'b1;
      bitIn8  = b;
      @(posedge clk);
      #1;
   endtask

   // 1-D Sobol point n for 8 bits: bit-reversed Gray code of n.
   function automatic int sobol8(input int n);
      logic [7:0] g;
      logic [7:0] r;
      g = 8'(n ^ (n >> 1));
      for (int i = 0; i < 8; i++) r[i] = g[7-i];
      return int'(r);
   endfunction

   // Random ordering of a window holding 'ones' ones.
   task automatic make_window(input int ones, output int w[8]);
      int t;
      int j;
      for (int i = 0; i < 8; i++) w[i] = (i < ones) ? 1 : 0;
      for (int i = 7; i > 0; i--) begin
         j = $urandom_range(i, 0);
         t = w[i]; w[i] = w[j]; w[j] = t;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; clear = 1'b0; bitIn = 1'b0;
      enable8 = 1'b0; clear8 = 1'b0; bitIn8 = 1'b0;
      #12;
      n_checks++; if (binOut !== 3'd0) begin n_fail++; $display("FAIL reset_binOut: got %0d expected 0", binOut); end
      n_checks++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL reset_outValid: got %0b expected 0", outValid); end
      n_checks++; if (satFlag !== 1'b0) begin n_fail++; $display("FAIL reset_satFlag: got %0b expected 0", satFlag); end
      n_checks++; if (binOut8 !== 8'd0 || outValid8 !== 1'b0) begin n_fail++; $display("FAIL reset_dut8: got bin=%0d valid=%0b expected 0/0", binOut8, outValid8); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_alternating();
      int b[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
      for (int i = 0; i < 8; i++) begin
         step(1'b1, b[i] != 0, 1'b0);
         if (i < 7) begin
            n_checks++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL alt_early_valid: bit %0d got %0b expected 0", i, outValid); end
         end
      end
      n_checks++; if (outValid !== 1'b1) begin n_fail++; $display("FAIL alt_valid: got %0b expected 1", outValid); end
      n_checks++; if (binOut !== 3'd4) begin n_fail++; $display("FAIL alt_binOut: got %0d expected 4", binOut); end
      n_checks++; if (satFlag !== 1'b0) begin n_fail++; $display("FAIL alt_sat: got %0b expected 0", satFlag); end
      step(1'b0, 1'b0, 1'b0);
      n_checks++; if (outValid !== 1'b0 || binOut !== 3'd4) begin n_fail++; $display("FAIL alt_pulse_drop: got valid=%0b bin=%0d expected 0/4", outValid, binOut); end
   endtask

   task automatic test_ones_zeros();
      for (int v = 1; v >= 0; v--) begin
         for (int i = 0; i < 8; i++) step(1'b1, v != 0, 1'b0);
         n_checks++; if (outValid !== 1'b1) begin n_fail++; $display("FAIL oz_valid: v=%0d got %0b expected 1", v, outValid); end
         n_checks++; if (binOut !== ((v != 0) ? 3'd7 : 3'd0)) begin n_fail++; $display("FAIL oz_binOut: v=%0d got %0d expected %0d", v, binOut, (v != 0) ? 7 : 0); end
         n_checks++; if (satFlag !== (v != 0)) begin n_fail++; $display("FAIL oz_sat: v=%0d got %0b expected %0b", v, satFlag, v != 0); end
      end
   endtask

   task automatic test_stall();
      // Stall cycles carry bitIn=1 so a counted stall would corrupt the sum.
      int en[12] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 1, 1};
      int b[12]  = '{1, 1, 0, 1, 1, 1, 0, 0, 1, 1, 1, 1};
      for (int c = 0; c < 12; c++) begin
         step(en[c] != 0, b[c] != 0, 1'b0);
         if (c < 11) begin
            n_checks++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL stall_early_valid: cycle %0d got %0b expected 0", c, outValid); end
         end
      end
      n_checks++; if (outValid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %0b expected 1", outValid); end
      n_checks++; if (binOut !== 3'd5) begin n_fail++; $display("FAIL stall_binOut: got %0d expected 5", binOut); end
   endtask

   task automatic test_back_to_back();
      int vals[3]    = '{2, 8, 5};
      int expb[3]    = '{2, 7, 5};
      int w[8];
      int stream[24];
      int pcyc[$];
      int pbin[$];
      int psat[$];
      for (int k = 0; k < 3; k++) begin
         make_window(vals[k], w);
         for (int i = 0; i < 8; i++) stream[k*8+i] = w[i];
      end
      for (int c = 0; c < 24; c++) begin
         step(1'b1, stream[c] != 0, 1'b0);
         if (outValid === 1'b1) begin
            pcyc.push_back(c);
            pbin.push_back(int'(binOut));
            psat.push_back(int'(satFlag));
         end
      end
      n_checks++; if (pcyc.size() != 3) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 3", pcyc.size()); end
      for (int k = 0; k < 3 && k < pcyc.size(); k++) begin
         n_checks++; if (pcyc[k] != 8*k+7) begin n_fail++; $display("FAIL b2b_cycle%0d: got %0d expected %0d", k, pcyc[k], 8*k+7); end
         n_checks++; if (pbin[k] != expb[k]) begin n_fail++; $display("FAIL b2b_bin%0d: got %0d expected %0d", k, pbin[k], expb[k]); end
         n_checks++; if (psat[k] != ((vals[k] == 8) ? 1 : 0)) begin n_fail++; $display("FAIL b2b_sat%0d: got %0d expected %0d", k, psat[k], vals[k] == 8); end
      end
   endtask

   task automatic test_clear();
      int w[8];
      make_window(6, w);
      for (int i = 0; i < 8; i++) step(1'b1, w[i] != 0, 1'b0);
      n_checks++; if (binOut !== 3'd6 || outValid !== 1'b1) begin n_fail++; $display("FAIL clr_pre: got bin=%0d valid=%0b expected 6/1", binOut, outValid); end
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      n_checks++; if (binOut !== 3'd6 || outValid !== 1'b0) begin n_fail++; $display("FAIL clr_hold: got bin=%0d valid=%0b expected 6/0", binOut, outValid); end
      make_window(3, w);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, w[i] != 0, 1'b0);
         if (i < 7) begin
            n_checks++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL clr_early_valid: bit %0d got %0b expected 0", i, outValid); end
         end
      end
      n_checks++; if (outValid !== 1'b1 || binOut !== 3'd3) begin n_fail++; $display("FAIL clr_next: got bin=%0d valid=%0b expected 3/1", binOut, outValid); end
   endtask

   task automatic test_clear_on_final();
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      n_checks++; if (outValid !== 1'b0 || binOut !== 3'd3) begin n_fail++; $display("FAIL clrfin_hold: got bin=%0d valid=%0b expected 3/0", binOut, outValid); end
      for (int i = 0; i < 8; i++) step(1'b1, i == 2, 1'b0);
      n_checks++; if (outValid !== 1'b1 || binOut !== 3'd1) begin n_fail++; $display("FAIL clrfin_next: got bin=%0d valid=%0b expected 1/1", binOut, outValid); end
   endtask

   task automatic test_reset_mid();
      int w[8];
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (binOut !== 3'd0 || outValid !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: got bin=%0d valid=%0b expected 0/0", binOut, outValid); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      make_window(6, w);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, w[i] != 0, 1'b0);
         if (i < 7) begin
            n_checks++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL rstmid_early_valid: bit %0d got %0b expected 0", i, outValid); end
         end
      end
      n_checks++; if (outValid !== 1'b1 || binOut !== 3'd6) begin n_fail++; $display("FAIL rstmid_fresh: got bin=%0d valid=%0b expected 6/1", binOut, outValid); end
   endtask

   task automatic test_random();
      int   win[$];
      int   s;
      int   exp_bin = 6;
      int   exp_sat = 0;
      logic exp_valid;
      logic en, b, clr;
      for (int c = 0; c < 400; c++) begin
         en  = ($urandom_range(0, 9) < 7);
         b   = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 39) == 0);
         step(en, b, clr);
         exp_valid = 1'b0;
         if (clr) begin
            win.delete();
         end else if (en) begin
            win.push_back(int'(b));
            if (win.size() == 8) begin
               s = 0;
               foreach (win[i]) s += win[i];
               exp_bin   = (s == 8) ? 7 : s;
               exp_sat   = (s == 8) ? 1 : 0;
               exp_valid = 1'b1;
               win.delete();
            end
         end
         n_checks++; if (outValid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid: cycle %0d got %0b expected %0b", c, outValid, exp_valid); end
         n_checks++; if (int'(binOut) != exp_bin || $isunknown(binOut)) begin n_fail++; $display("FAIL rnd_binOut: cycle %0d got %0d expected %0d", c, binOut, exp_bin); end
         if (exp_valid) begin
            n_checks++; if (int'(satFlag) != exp_sat) begin n_fail++; $display("FAIL rnd_sat: cycle %0d got %0b expected %0d", c, satFlag, exp_sat); end
         end
      end
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_sobol_sweep();
      int ks[5] = '{0, 1, 128, 255, 256};
      int expv;
      for (int j = 0; j < 5; j++) begin
         for (int n = 0; n < 256; n++) begin
            step8(sobol8(n) < ks[j]);
            if (n == 254) begin
               n_checks++; if (outValid8 !== 1'b0) begin n_fail++; $display("FAIL sobol_early_valid: k=%0d got %0b expected 0", ks[j], outValid8); end
            end
         end
         expv = (ks[j] == 256) ? 255 : ks[j];
         n_checks++; if (outValid8 !== 1'b1) begin n_fail++; $display("FAIL sobol_valid: k=%0d got %0b expected 1", ks[j], outValid8); end
         n_checks++; if (int'(binOut8) != expv) begin n_fail++; $display("FAIL sobol_binOut: k=%0d got %0d expected %0d", ks[j], binOut8, expv); end
         n_checks++; if (int'(satFlag8) != ((ks[j] == 256) ? 1 : 0)) begin n_fail++; $display("FAIL sobol_sat: k=%0d got %0b expected %0d", ks[j], satFlag8, ks[j] == 256); end
      end
      enable8 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_alternating();
      test_ones_zeros();
      test_stall();
      test_back_to_back();
      test_clear();
      test_clear_on_final();
      test_reset_mid();
      test_random();
      test_sobol_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
